audio_udp_packer: RTL
=====================

# audio_udp_packer

Parametrised successor to the fixed two-channel audio-to-UDP path. Captures multi-channel PCM sample sets and serialises them big-endian into an internal byte FIFO. Emits fixed-length UDP payload frames, each prefixed with a 32-bit sequence number, on a byte-wide valid/ready stream toward the MAC/UDP transmitter. Single clock domain; any crossing into the GMII clock is done downstream.

## Interface
- CH_NUM, 2: channels per sample set (1..8)
- SAMPLE_W, 16: bits per channel sample; multiple of 8, 8..32
- PAYLOAD_BYTES, 1024: audio bytes per frame, excluding the 4-byte header; multiple of BPS = CH_NUM*SAMPLE_W/8
- FIFO_DEPTH, 2048: byte FIFO depth; power of two, >= PAYLOAD_BYTES + BPS
- sys_clk  in  1  system clock, 50 MHz
- rst  in  1  **synchronous, active-high reset**
- enable  in  1  capture enable; when 0, sample_valid is ignored and not counted
- sample_valid  in  1  one-cycle strobe; sample_data is valid
- sample_data  in  CH_NUM*SAMPLE_W  channel 0 in the MSBs
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts the byte
- tx_data  out  8  frame byte
- tx_first  out  1  first header byte of a frame
- tx_last  out  1  final payload byte of a frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  committed bytes in the FIFO
- frame_seq  out  32  sequence number of the next frame to start
- drop_cnt  out  16  dropped sample sets; saturates at 0xFFFF

## Operation
- **Capture**
  - On sample_valid && enable with the serialiser idle and free space (FIFO_DEPTH - fifo_level) >= BPS, latch sample_data.
  - Write its BPS bytes to the FIFO on the next BPS cycles, one per cycle, MSB byte first. Channel order is 0..CH_NUM-1; each sample is big-endian.
- **Drops**
  - A set is dropped whole, with drop_cnt incremented, if the serialiser is busy or space is insufficient.
  - A set is never partially written.
- **Frame FSM** (states IDLE, HDR, PAY)
  - IDLE -> HDR when fifo_level >= PAYLOAD_BYTES.
  - HDR sends frame_seq as 4 bytes, big-endian. tx_first is asserted on byte 0.
  - HDR -> PAY after the 4th handshake.
  - PAY pops PAYLOAD_BYTES bytes. tx_last is asserted on the final byte.
  - PAY -> IDLE after the last handshake; frame_seq increments (mod 2^32) on that same edge.
- A frame starts only when its full payload is already buffered, so PAY never underflows.
- A byte transfers when tx_valid && tx_ready.
- Simultaneous FIFO write and pop in one cycle: fifo_level unchanged.
- Reset values: tx_valid=0, tx_data=0, tx_first=0, tx_last=0, fifo_level=0, frame_seq=0, drop_cnt=0; FSM in IDLE; serialiser idle; FIFO emptied.

## Timing
- sample_valid at cycle t: bytes written on edges t+1..t+BPS. fifo_level counts each byte from the cycle after its write.
- The earliest accepted next sample_valid is at cycle t+BPS.
- tx_data, tx_valid, tx_first and tx_last are registered.
  - Entering HDR: tx_valid rises one cycle after the IDLE->HDR decision.
  - Back-to-back frames: IDLE lasts one cycle between frames.
- While tx_valid && !tx_ready, tx_data, tx_first and tx_last hold stable.
- After tx_valid asserts, it stays asserted until the handshake. It deasserts only after tx_last is accepted.
- Throughput in PAY: one byte per cycle with tx_ready held high.
- Reset mid-frame: the next cycle has tx_valid=0, and the partial frame is abandoned.

## Structure
- Package audio_pkt_pkg holds:
  - SEQ_BYTES=4
  - frame-FSM state enum
  - BPS helper function
  - parameter-legality checks (elaborated assertions)
- Sub-module audio_byte_fifo:
  - synchronous byte FIFO, ports sys_clk/rst
  - registered read with pop/level
  - full/empty derived from level
- Top contains the serialiser, drop logic, frame FSM and output register.

## Test plan
Test configuration: CH_NUM=2, SAMPLE_W=16, PAYLOAD_BYTES=8, FIFO_DEPTH=16.
1. Sets {0x1234,0xABCD} and {0x5678,0xEF01}, 8 cycles apart, tx_ready=1 -> stream 00 00 00 00 12 34 AB CD 56 78 EF 01; tx_first on the first 00, tx_last on 01; frame_seq becomes 1.
2. Four more sets -> second header is 00 00 00 01; drop_cnt=0.
3. tx_ready toggled randomly during frame 1 -> identical byte sequence; outputs held stable whenever stalled.
4. tx_ready=0, five sets -> fifo_level=16; 5th set dropped; drop_cnt=1; no partial bytes written.
5. Second sample_valid 2 cycles after the first -> dropped, drop_cnt=1; a valid 4 cycles later is accepted.
6. rst asserted after the 6th byte of frame 0 -> tx_valid=0 next cycle; fifo_level=0, frame_seq=0, drop_cnt=0; the next frame restarts with header 00 00 00 00.

Source files
------------

// File: rtl/audio_pkt_pkg.sv
// audio_pkt_pkg: shared constants, frame FSM states and
// configuration helpers for the audio-to-UDP packer.
package audio_pkt_pkg;

    localparam int SEQ_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY
    } frame_state_e;

    function automatic int bps_f(input int ch_num, input int sample_w);
        return ch_num * sample_w / 8;
    endfunction

    function automatic bit cfg_ok(
        input int ch_num,
        input int sample_w,
        input int payload,
        input int depth
    );
        int bps;
        bps = bps_f(ch_num, sample_w);
        if (ch_num < 1 || ch_num > 8) return 1'b0;
        if (sample_w < 8 || sample_w > 32) return 1'b0;
        if (sample_w % 8 != 0) return 1'b0;
        if (bps < 1 || payload < 1) return 1'b0;
        if (payload % bps != 0) return 1'b0;
        if (depth < 1 || (depth & (depth - 1)) != 0) return 1'b0;
        return depth >= payload + bps;
    endfunction

endpackage

// File: rtl/audio_byte_fifo.sv
// audio_byte_fifo: synchronous byte FIFO with a registered
// head-of-queue read port, pop strobe and occupancy level.
module audio_byte_fifo #(
    parameter  int DEPTH = 2048,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [LW-1:0] level_q;
    logic [7:0]    rd_data_q;

    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign rd_data  = rd_data_q;
    assign level    = level_q;
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);

    // Storage array; contents need no reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointers, occupancy and the head byte prefetched for the reader.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= mem_q[rd_ptr_d];
            level_q   <= level_q + LW'(wr_en) - LW'(pop);
        end
    end

endmodule

// File: rtl/audio_udp_packer.sv
// audio_udp_packer: serialises PCM sample sets into a byte FIFO and
// emits sequence-numbered fixed-length frames on a valid/ready stream.
module audio_udp_packer
    import audio_pkt_pkg::*;
#(
    parameter int CH_NUM        = 2,
    parameter int SAMPLE_W      = 16,
    parameter int PAYLOAD_BYTES = 1024,
    parameter int FIFO_DEPTH    = 2048
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           sample_valid,
    input  logic [CH_NUM*SAMPLE_W-1:0]     sample_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [7:0]                     tx_data,
    output logic                           tx_first,
    output logic                           tx_last,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [31:0]                    frame_seq,
    output logic [15:0]                    drop_cnt
);

    localparam int BPS  = bps_f(CH_NUM, SAMPLE_W);
    localparam int DW   = CH_NUM * SAMPLE_W;
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SCW  = $clog2(BPS + 1);
    localparam int CMAX = (PAYLOAD_BYTES > SEQ_BYTES) ? PAYLOAD_BYTES : SEQ_BYTES;
    localparam int CW   = $clog2(CMAX + 1);

    if (!cfg_ok(CH_NUM, SAMPLE_W, PAYLOAD_BYTES, FIFO_DEPTH)) begin : g_bad_cfg
        $error("audio_udp_packer: illegal parameter set");
    end

    logic [DW-1:0]  sd_q, sd_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [15:0]    drop_q, drop_d;
    logic [LW-1:0]  space;
    logic           busy, offer, accept;
    logic           ser_wr;
    logic [7:0]     ser_byte;

    frame_state_e   st_q, st_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    seq_q, seq_d;
    logic [7:0]     txd_q, txd_d;
    logic           txv_q, txv_d;
    logic           txf_q, txf_d;
    logic           txl_q, txl_d;
    logic           pay_pop, hs;

    logic [7:0]     fifo_rd;
    logic           fifo_full, fifo_empty;

    audio_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wr_en   (ser_wr && !fifo_full),
        .wr_data (ser_byte),
        .pop     (pay_pop && !fifo_empty),
        .rd_data (fifo_rd),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Capture admits a set only when all of its bytes are guaranteed room.
    assign space    = LW'(FIFO_DEPTH) - fifo_level;
    assign busy     = (sc_q != '0);
    assign offer    = sample_valid && enable;
    assign accept   = offer && !busy && (space >= LW'(BPS));
    assign ser_wr   = accept || busy;
    assign ser_byte = accept ? sample_data[DW-1 -: 8] : sd_q[DW-1 -: 8];
    assign hs       = txv_q && tx_ready;

    // Serialiser: first byte goes straight in, the rest shift out MSB first.
    always_comb begin
        sd_d   = sd_q;
        sc_d   = sc_q;
        drop_d = drop_q;
        if (accept) begin
            sd_d = sample_data << 8;
            sc_d = SCW'(BPS - 1);
        end else if (busy) begin
            sd_d = sd_q << 8;
            sc_d = sc_q - 1'b1;
        end
        if (offer && !accept && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Frame FSM and output register; next byte loads on each handshake.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        txf_d   = txf_q;
        txl_d   = txl_q;
        pay_pop = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (fifo_level >= LW'(PAYLOAD_BYTES)) begin
                    st_d  = ST_HDR;
                    txv_d = 1'b1;
                    txd_d = seq_q[31:24];
                    txf_d = 1'b1;
                    txl_d = 1'b0;
                    cnt_d = CW'(1);
                end
            end
            ST_HDR: begin
                if (hs) begin
                    txf_d = 1'b0;
                    if (cnt_q == CW'(SEQ_BYTES)) begin
                        st_d    = ST_PAY;
                        txd_d   = fifo_rd;
                        pay_pop = 1'b1;
                        cnt_d   = CW'(1);
                        txl_d   = (PAYLOAD_BYTES == 1);
                    end else begin
                        txd_d = seq_q[8*(SEQ_BYTES-1-int'(cnt_q)) +: 8];
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (hs) begin
                    if (cnt_q == CW'(PAYLOAD_BYTES)) begin
                        st_d  = ST_IDLE;
                        txv_d = 1'b0;
                        txl_d = 1'b0;
                        seq_d = seq_q + 32'd1;
                    end else begin
                        txd_d   = fifo_rd;
                        pay_pop = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        txl_d   = (cnt_q == CW'(PAYLOAD_BYTES - 1));
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sd_q   <= '0;
            sc_q   <= '0;
            drop_q <= '0;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            seq_q  <= '0;
            txd_q  <= '0;
            txv_q  <= 1'b0;
            txf_q  <= 1'b0;
            txl_q  <= 1'b0;
        end else begin
            sd_q   <= sd_d;
            sc_q   <= sc_d;
            drop_q <= drop_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            txd_q  <= txd_d;
            txv_q  <= txv_d;
            txf_q  <= txf_d;
            txl_q  <= txl_d;
        end
    end

    assign tx_valid  = txv_q;
    assign tx_data   = txd_q;
    assign tx_first  = txf_q;
    assign tx_last   = txl_q;
    assign frame_seq = seq_q;
    assign drop_cnt  = drop_q;

endmodule
